// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run controller wrapped around a shared 3-consecutive-ones
// Mealy detector. It owns the detector's reset and input gate. It opens a
// window of win_len RUN cycles and counts detector hits. The run ends on
// reaching target (success) or on window expiry (timeout). The result is
// then reported with a one-cycle done pulse.
//
// Optional feature: define DET_CTRL_ABORT_EN to add an abort input. abort
// ends a run from ARM or RUN with success=0 and timeout=0. The hit count is
// frozen at its value, and a hit in the abort cycle still counts.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle run request, honoured only in IDLE
//   win_len, target     window length / hit target, captured at start
//   d_in                raw serial stream from the source
//   abort               (DET_CTRL_ABORT_EN only) terminate current run
//   det_reset           detector reset (controller reset or ARM)
//   det_d_in            gated stream to detector (d_in only in RUN)
//   det_d_out           detector hit output (combinational Mealy)
//   busy                high in ARM and RUN
//   done                one-cycle completion pulse
//   success, timeout    run outcome, held until next start
//   hit_cnt             hits in current/last run, held until next start
module seq_det_ctrl #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] target,
  input  logic             d_in,
`ifdef DET_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             det_reset,
  output logic             det_d_in,
  input  logic             det_d_out,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic             timeout,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] tgt;
  logic             abort_w;
  logic             hit;
  logic             reach;
  logic             last;
  logic [CNT_W:0]   hit_inc;

`ifdef DET_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Hits only count while the window is open.
  assign hit     = (state == S_RUN) && det_d_out;
  // The comparison uses one extra bit, so a saturated counter can never
  // alias onto a small target.
  assign hit_inc = {1'b0, hit_cnt} + (CNT_W+1)'(1);
  assign reach   = hit && (hit_inc == {1'b0, tgt});
  assign last    = (win_cnt == WIN_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_ARM;
      S_ARM: begin
        if (abort_w || (tgt == '0) || (win_cnt == '0)) state_nxt = S_DONE;
        else                                            state_nxt = S_RUN;
      end
      S_RUN:  if (abort_w || reach || last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state == S_ARM) || (state == S_RUN);
    done      = (state == S_DONE);
    // The detector clears during ARM, so history from an earlier run
    // cannot produce a hit in this run.
    det_reset = reset || (state == S_ARM);
    det_d_in  = (state == S_RUN) && d_in;
  end

  // Run datapath: window/target capture, hit counting, outcome flags
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
      tgt     <= '0;
      hit_cnt <= '0;
      success <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            win_cnt <= win_len;
            tgt     <= target;
            hit_cnt <= '0;
            success <= 1'b0;
            timeout <= 1'b0;
          end
        end
        S_ARM: begin
          if (!abort_w) begin
            if (tgt == '0)          success <= 1'b1;
            else if (win_cnt == '0) timeout <= 1'b1;
          end
        end
        S_RUN: begin
          if (hit && (hit_cnt != '1)) hit_cnt <= hit_inc[CNT_W-1:0];
          win_cnt <= win_cnt - WIN_W'(1);
          // A hit on the last window cycle reports success, not timeout.
          if (!abort_w) begin
            if (reach)     success <= 1'b1;
            else if (last) timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Run controller for the shared 3-consecutive-ones Mealy detector (ports clk, reset, d_in, d_out).
- Owns the detector's reset and its input gate. Opens a measurement window of programmable length and counts detector hits.
- Ends the window on a target hit count or on timeout, then reports the result.
- Sits between the serial source and the detector instance. Software or a parent FSM starts it with a one-cycle pulse.

Parameters:
- CNT_W, 8, width of hit counter and target.
- WIN_W, 16, width of window length and window counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle run request; sampled only in IDLE.
- win_len  input  WIN_W  window length in RUN cycles; sampled at start.
- target  input  CNT_W  hit count that ends the run successfully; sampled at start.
- d_in  input  1  raw serial bit stream.
- det_reset  output  1  drives the detector reset.
- det_d_in  output  1  drives the detector d_in.
- det_d_out  input  1  detector d_out (Mealy, combinational from det_d_in and detector state).
- busy  output  1  high in ARM and RUN.
- done  output  1  one-cycle completion pulse.
- success  output  1  run ended by reaching target; held until next start.
- timeout  output  1  run ended by window expiry; held until next start.
- hit_cnt  output  CNT_W  hits counted in the current or last run; held until next start.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high, port name reset. All state updates on the rising edge of clk.
- Reset: state=IDLE; busy=0, done=0, success=0, timeout=0, hit_cnt=0, det_d_in=0.
- det_reset = reset OR (state==ARM). The detector is held in reset while the controller is in reset.
- det_d_in = d_in in RUN, otherwise 0. This stops spurious hits outside the window.
- IDLE, start=1:
  - Latch win_len into win_cnt and target into tgt.
  - Clear hit_cnt, success and timeout.
  - Go to ARM. start is ignored in every other state.
- ARM: lasts exactly 1 cycle; the detector resets at the next edge.
  - tgt==0: go to DONE with success=1.
  - Else win_cnt==0: go to DONE with timeout=1.
  - Else go to RUN.
- RUN, every cycle:
  - hit = det_d_out.
  - If hit, hit_cnt <= hit_cnt+1, saturating at all ones.
  - win_cnt decrements.
  - If hit and hit_cnt+1==tgt: go to DONE, success=1.
  - Else if win_cnt==1: go to DONE, timeout=1.
  - A hit and window expiry in the same cycle: success wins and timeout stays 0.
  - Exactly win_len d_in bits are presented to the detector unless the run ends early.
- DONE: 1 cycle, done=1, busy=0, then IDLE. A start asserted during DONE is ignored.
- Latency:
  - start to first RUN cycle is 2 cycles (IDLE->ARM->RUN).
  - The final RUN cycle is followed by the done pulse in the next cycle.
- Reset asserted in any state: immediate return to IDLE at the next edge with reset values. No done pulse is generated.
- The detector sees 0 on det_d_in outside RUN, so its state after a run never leaks into the next run; ARM also resets it.

Optional Feature:
- Macro DET_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in ARM or RUN sends the FSM to DONE next edge, with success=0, timeout=0 and hit_cnt frozen.
  - A hit counted in the same cycle as abort still increments hit_cnt.
  - abort has priority over success and timeout in the same cycle.
- Not defined: port absent; runs end only on success, timeout or reset.

Test Plan:
- Reset, then start with win_len=10, target=1, d_in=1,1,1,... -> RUN cycles 1-3; hit in RUN cycle 3; done pulse next cycle; success=1, hit_cnt=1, timeout=0.
- win_len=8, target=5, d_in all 0 -> 8 RUN cycles with no hit; done; timeout=1, hit_cnt=0; det_d_in=0 after RUN.
- win_len=9, target=3, d_in all 1 -> hits in RUN cycles 3, 6 and 9. The third hit coincides with window expiry, so success=1, timeout=0, hit_cnt=3.
- target=0 -> ARM then DONE; success=1, hit_cnt=0. Separately win_len=0, target=2 -> ARM then DONE; timeout=1. Neither case has a RUN cycle.
- Reset asserted in RUN cycle 4 of a 20-cycle window -> IDLE next edge; all outputs 0; no done pulse. start during RUN and during DONE is ignored, with no restart.
- With DET_CTRL_ABORT_EN, abort in RUN cycle 5 after 1 hit -> DONE; success=0, timeout=0, hit_cnt=1.
